reset_sequencer: RTL and testbench

- Ordered reset-release controller for NUM_DOMAINS downstream blocks, e.g. the PE array, the SRAM buffers, the DMA engine and the host interface.
- Driven from the already-synchronised system reset. It holds every domain in reset, then releases the domains one at a time in index order.
- After each release it waits for that domain's ready handshake, with an optional watchdog, before moving to the next.
- Accepts software reset requests for all domains or for a single domain once the sequence is complete.

---
 rtl/reset_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds NUM_DOMAINS reset domains, then releases them one at a
// time in index order, waiting for each domain's ready flag before moving on.
// Once the sequence is complete, software may reset all domains or just one.
// Optional watchdog: define RST_SEQ_WATCHDOG_EN to bound each ready wait to
// TIMEOUT_CYCLES edges and record a sticky timeout flag plus the failing index.
module reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk_i,
  input  logic                   async_reset_i,
  input  logic [NUM_DOMAINS-1:0] domain_ready_i,
  input  logic                   sw_rst_valid_i,
  input  logic                   sw_rst_all_i,
  input  logic [IW-1:0]          sw_rst_sel_i,
  output logic                   sw_rst_ready_o,
  output logic [NUM_DOMAINS-1:0] domain_rst_o,
  output logic                   all_ready_o,
  output logic                   busy_o,
  output logic                   timeout_err_o,
  output logic [IW-1:0]          err_domain_o
);

  localparam int MAXC0 = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC  = (MAXC0 > TIMEOUT_CYCLES) ? MAXC0 : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAXC + 1);

  localparam logic [2:0] S_HOLD  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_SHOLD = 3'd4;
  localparam logic [2:0] S_SWAIT = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d, idx_nx;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   all_ready_q, busy_q, swr_q;
  logic                   rdy_eff, to_hit, wd_clr, te_clr;

  assign idx_nx = idx_q + 1'b1;

  // Main sequencing: next state, index, counter and per-domain reset bits.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    wd_clr  = 1'b0;
    te_clr  = 1'b0;
    // A watchdog expiry is treated exactly like a sampled ready.
    rdy_eff = domain_ready_i[idx_q] | to_hit;
    case (state_q)
      S_HOLD, S_SHOLD: begin
        if (cnt_q == '0) begin
          rst_d[idx_q] = 1'b0;
          wd_clr       = 1'b1;
          state_d      = (state_q == S_HOLD) ? S_WAIT : S_SWAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (rdy_eff) begin
          if (idx_q == IW'(NUM_DOMAINS - 1)) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES == 0) begin
            rst_d[idx_nx] = 1'b0;
            idx_d         = idx_nx;
            wd_clr        = 1'b1;
          end else begin
            cnt_d   = CW'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          rst_d[idx_nx] = 1'b0;
          idx_d         = idx_nx;
          wd_clr        = 1'b1;
          state_d       = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SWAIT: begin
        if (rdy_eff) state_d = S_DONE;
      end
      S_DONE: begin
        if (sw_rst_valid_i) begin
          if (sw_rst_all_i) begin
            rst_d   = '1;
            te_clr  = 1'b1;
            idx_d   = '0;
            cnt_d   = CW'(HOLD_CYCLES - 1);
            state_d = S_HOLD;
          end else if (int'(sw_rst_sel_i) < NUM_DOMAINS) begin
            rst_d[sw_rst_sel_i] = 1'b1;
            idx_d               = sw_rst_sel_i;
            cnt_d               = CW'(HOLD_CYCLES - 1);
            state_d             = S_SHOLD;
          end
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // State and registered outputs; status flags follow the next state so they
  // change on the same edge as the transition.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      state_q     <= S_HOLD;
      idx_q       <= '0;
      cnt_q       <= CW'(HOLD_CYCLES - 1);
      rst_q       <= '1;
      all_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      swr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rst_q       <= rst_d;
      all_ready_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_DONE);
      swr_q       <= (state_d == S_DONE);
    end
  end

  assign domain_rst_o   = rst_q;
  assign all_ready_o    = all_ready_q;
  assign busy_o         = busy_q;
  assign sw_rst_ready_o = swr_q;

`ifdef RST_SEQ_WATCHDOG_EN
  logic [CW-1:0] wd_q, wd_d;
  logic          te_q, te_d;
  logic [IW-1:0] ed_q, ed_d;
  logic          waiting;

  assign waiting = (state_q == S_WAIT) || (state_q == S_SWAIT);
  assign to_hit  = waiting && !domain_ready_i[idx_q] &&
                   (wd_q == CW'(TIMEOUT_CYCLES - 1));

  // Watchdog: count not-ready edges while waiting; flag and record on expiry.
  always_comb begin
    wd_d = wd_q;
    te_d = te_q;
    ed_d = ed_q;
    if (wd_clr) begin
      wd_d = '0;
    end else if (waiting && !domain_ready_i[idx_q]) begin
      if (to_hit) begin
        te_d = 1'b1;
        ed_d = idx_q;
        wd_d = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
    if (te_clr) te_d = 1'b0;
  end

  // Watchdog registers.
  always_ff @(posedge clk_i or posedge async_reset_i) begin
    if (async_reset_i) begin
      wd_q <= '0;
      te_q <= 1'b0;
      ed_q <= '0;
    end else begin
      wd_q <= wd_d;
      te_q <= te_d;
      ed_q <= ed_d;
    end
  end

  assign timeout_err_o = te_q;
  assign err_domain_o  = ed_q;
`else
  logic unused_wd;
  assign unused_wd     = wd_clr ^ te_clr;
  assign to_hit        = 1'b0;
  assign timeout_err_o = 1'b0;
  assign err_domain_o  = '0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes cycle-tagged expected
// output snapshots; a negedge monitor pops and compares them as cycles pass.
// Two instances: GAP_CYCLES=2 (main) and GAP_CYCLES=0 (gap0).
module tb_reset_sequencer;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] rdy = 3'b111;
  logic v = 1'b0, all_s = 1'b0;
  logic [1:0] sel = 2'd0;
  logic srr, ar, bz, te;
  logic [N-1:0] drst;
  logic [1:0] ed;

  logic [N-1:0] rdy0 = 3'b111;
  logic v0 = 1'b0, all0 = 1'b0;
  logic [1:0] sel0 = 2'd0;
  logic srr0, ar0, bz0, te0;
  logic [N-1:0] drst0;
  logic [1:0] ed0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .async_reset_i(rst), .domain_ready_i(rdy), .sw_rst_valid_i(v),
    .sw_rst_all_i(all_s), .sw_rst_sel_i(sel), .sw_rst_ready_o(srr), .domain_rst_o(drst),
    .all_ready_o(ar), .busy_o(bz), .timeout_err_o(te), .err_domain_o(ed));

  reset_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) dut0 (
    .clk_i(clk), .async_reset_i(rst), .domain_ready_i(rdy0), .sw_rst_valid_i(v0),
    .sw_rst_all_i(all0), .sw_rst_sel_i(sel0), .sw_rst_ready_o(srr0), .domain_rst_o(drst0),
    .all_ready_o(ar0), .busy_o(bz0), .timeout_err_o(te0), .err_domain_o(ed0));

  typedef struct {
    int cyc; bit d; logic [2:0] r; logic a, b, s, t; logic [1:0] e;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  int cyc;

  // Edge number since the last reset release.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0; else cyc <= cyc + 1;

  task automatic push(int c, bit d, logic [2:0] r, logic a, logic b, logic s,
                      logic t, logic [1:0] e);
    exp_t x;
    x.cyc = c; x.d = d; x.r = r; x.a = a; x.b = b; x.s = s; x.t = t; x.e = e;
    q.push_back(x);
  endtask

  // Monitor: compare every expectation whose cycle has arrived.
  logic [8:0] act_v, exp_v;
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        act_v = q[i].d ? {drst0, ar0, bz0, srr0, te0, ed0} : {drst, ar, bz, srr, te, ed};
        exp_v = {q[i].r, q[i].a, q[i].b, q[i].s, q[i].t, q[i].e};
        checks++;
        if (q[i].cyc != cyc || act_v !== exp_v) begin
          errors++;
          $display("FAIL %s cyc %0d (now %0d): got rst/ar/bz/srdy/terr/edom=%b want %b",
                   q[i].d ? "gap0" : "main", q[i].cyc, cyc, act_v, exp_v);
        end
        q.delete(i);
      end
    end
  end

  task automatic wait_cyc(int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty();
    int k = 0;
    while (q.size() != 0 && k < 200) begin @(negedge clk); #1; k++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      q.delete();
    end
  endtask

  // Power-up timing with GAP=2, all ready.
  task automatic push_s1();
    push(3, 0, 3'b111, 0, 1, 0, 0, 0);
    push(4, 0, 3'b110, 0, 1, 0, 0, 0);
    push(6, 0, 3'b110, 0, 1, 0, 0, 0);
    push(7, 0, 3'b100, 0, 1, 0, 0, 0);
    push(10, 0, 3'b000, 0, 1, 0, 0, 0);
    push(11, 0, 3'b000, 1, 0, 1, 0, 0);
  endtask

  // Power-up timing with GAP=0.
  task automatic push_g0();
    push(4, 1, 3'b110, 0, 1, 0, 0, 0);
    push(5, 1, 3'b100, 0, 1, 0, 0, 0);
    push(6, 1, 3'b000, 0, 1, 0, 0, 0);
    push(7, 1, 3'b000, 1, 0, 1, 0, 0);
  endtask

  // Assert async reset away from the clock edge, expect reset values at once.
  task automatic do_reset(logic [2:0] r);
    wait_empty();
    rdy = r;
    rst = 1'b1;
    push(0, 0, 3'b111, 0, 1, 0, 0, 0);
    push(0, 1, 3'b111, 0, 1, 0, 0, 0);
    #12 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    // Power-up.
    push(0, 0, 3'b111, 0, 1, 0, 0, 0);
    push(0, 1, 3'b111, 0, 1, 0, 0, 0);
    push_s1();
    push_g0();
    #22 rst = 1'b0;

    // Single-domain software reset of domain 2, accepted at edge 15.
    wait_cyc(14);
    v = 1'b1; all_s = 1'b0; sel = 2'd2;
    push(15, 0, 3'b100, 0, 1, 0, 0, 0);
    push(16, 0, 3'b100, 0, 1, 0, 0, 0);
    push(17, 0, 3'b100, 0, 1, 0, 0, 0);
    push(18, 0, 3'b100, 0, 1, 0, 0, 0);
    push(19, 0, 3'b000, 0, 1, 0, 0, 0);
    push(20, 0, 3'b000, 1, 0, 1, 0, 0);
    wait_cyc(15);
    v = 1'b0;

    // Full software reset accepted at edge 23; sequence restarts.
    wait_cyc(22);
    v = 1'b1; all_s = 1'b1;
    push(23, 0, 3'b111, 0, 1, 0, 0, 0);
    push(27, 0, 3'b110, 0, 1, 0, 0, 0);
    push(28, 0, 3'b110, 0, 1, 0, 0, 0);
    wait_cyc(23);
    v = 1'b0;

    // Async reset while in GAP (between edges 28 and 29); timing restarts.
    wait_cyc(28);
    do_reset(3'b111);
    push_s1();
    push_g0();
    wait_cyc(14);
    wait_empty();

`ifdef RST_SEQ_WATCHDOG_EN
    // Domain 1 never becomes ready: watchdog fires at edge 23.
    do_reset(3'b101);
    push_g0();
    push(4, 0, 3'b110, 0, 1, 0, 0, 0);
    push(7, 0, 3'b100, 0, 1, 0, 0, 0);
    push(22, 0, 3'b100, 0, 1, 0, 0, 0);
    push(23, 0, 3'b100, 0, 1, 0, 1, 1);
    push(25, 0, 3'b000, 0, 1, 0, 1, 1);
    push(26, 0, 3'b000, 1, 0, 1, 1, 1);
    // Full software reset at edge 28 clears the flag; err_domain is kept.
    wait_cyc(27);
    v = 1'b1; all_s = 1'b1;
    push(28, 0, 3'b111, 0, 1, 0, 0, 1);
    push(32, 0, 3'b110, 0, 1, 0, 0, 1);
    push(35, 0, 3'b100, 0, 1, 0, 0, 1);
    push(38, 0, 3'b000, 0, 1, 0, 0, 1);
    push(39, 0, 3'b000, 1, 0, 1, 0, 1);
    wait_cyc(28);
    v = 1'b0; rdy = 3'b111;
    wait_cyc(40);
    wait_empty();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
